// File: rtl/sseg_scan_ctrl.sv
// Purpose: scan sequencer for the 4-digit seven-segment datapath; owns the committed display value.
// Latency: all outputs registered; a loaded value commits at the next frame boundary (1 to 4*2^DIV_BITS enabled cycles).
// Backpressure: none; load is always accepted (latest wins), en=0 freezes scanning and commits.
//
// Ports:
//   clk, rst                    rising-edge clock, async active-high reset
//   en                          scan enable (freezes prescaler, digit_sel, commits when low)
//   load                        one-cycle strobe capturing data_in/hex_dec_in/sign_in into the shadow
//   data_in, hex_dec_in, sign_in  new display value, mode and sign
//   data, hex_dec, sign         committed display value presented to the datapath
//   digit_sel                   active digit index 0..3
//   pending                     shadow holds a value not yet committed
//   tick                        pulse when digit_sel advances
//   frame_done                  pulse when digit_sel wraps 3->0

module sseg_scan_ctrl #(
    parameter int DIV_BITS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        hex_dec_in,
    input  logic        sign_in,
    output logic [15:0] data,
    output logic        hex_dec,
    output logic        sign,
    output logic [1:0]  digit_sel,
    output logic        pending,
    output logic        tick,
    output logic        frame_done
);

    logic [DIV_BITS-1:0] cnt;
    logic [15:0]         shadow_data;
    logic                shadow_hex_dec;
    logic                shadow_sign;

    logic wrap;
    logic frame_bnd;

    // A digit step happens only on an enabled cycle with the prescaler at its top value,
    // so dropping en on that exact cycle suppresses the step.
    assign wrap      = en && (cnt == {DIV_BITS{1'b1}});
    assign frame_bnd = wrap && (digit_sel == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            digit_sel      <= 2'd0;
            data           <= 16'h0000;
            hex_dec        <= 1'b0;
            sign           <= 1'b0;
            shadow_data    <= 16'h0000;
            shadow_hex_dec <= 1'b0;
            shadow_sign    <= 1'b0;
            pending        <= 1'b0;
            tick           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            if (en) begin
                cnt <= cnt + DIV_BITS'(1);
            end

            tick       <= wrap;
            frame_done <= frame_bnd;

            if (wrap) begin
                digit_sel <= digit_sel + 2'd1;
            end

            // Commit reads the shadow as held before this edge, so a load landing on the
            // boundary cycle is not shown until the following frame.
            if (frame_bnd && pending) begin
                data    <= shadow_data;
                hex_dec <= shadow_hex_dec;
                sign    <= shadow_sign;
            end

            if (load) begin
                shadow_data    <= data_in;
                shadow_hex_dec <= hex_dec_in;
                shadow_sign    <= sign_in;
            end

            // A fresh load always leaves a value pending, even when it coincides with a commit.
            if (load) begin
                pending <= 1'b1;
            end else if (frame_bnd) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic        hex_dec_in;
    logic        sign_in;
    logic [15:0] data;
    logic        hex_dec;
    logic        sign;
    logic [1:0]  digit_sel;
    logic        pending;
    logic        tick;
    logic        frame_done;

    int n_vec;
    int n_err;
    int pos;   // enabled edges since reset release

    sseg_scan_ctrl #(.DIV_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .hex_dec_in (hex_dec_in),
        .sign_in    (sign_in),
        .data       (data),
        .hex_dec    (hex_dec),
        .sign       (sign),
        .digit_sel  (digit_sel),
        .pending    (pending),
        .tick       (tick),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (en && !rst) pos++;
    endtask

    task automatic goto_pos(input int p);
        int guard;
        guard = 0;
        while ((pos % 16) != p && guard < 64) begin
            step();
            guard++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        data_in = 16'h0000; hex_dec_in = 1'b0; sign_in = 1'b0;
        pos = 0;
        step(); step();
        n_vec++; if (data !== 16'h0000) begin n_err++; $display("FAIL reset_data got %h want 0000", data); end
        n_vec++; if (hex_dec !== 1'b0) begin n_err++; $display("FAIL reset_hex_dec got %b want 0", hex_dec); end
        n_vec++; if (sign !== 1'b0) begin n_err++; $display("FAIL reset_sign got %b want 0", sign); end
        n_vec++; if (digit_sel !== 2'd0) begin n_err++; $display("FAIL reset_digit_sel got %0d want 0", digit_sel); end
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got %b want 0", pending); end
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b want 0", tick); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        rst = 1'b0; en = 1'b1; pos = 0;
    endtask

    task automatic test_scan();
        for (int k = 1; k <= 40; k++) begin
            step();
            n_vec++; if (digit_sel !== 2'((k / 4) % 4)) begin n_err++; $display("FAIL scan_digit_sel cyc %0d got %0d want %0d", k, digit_sel, (k / 4) % 4); end
            n_vec++; if (tick !== ((k % 4) == 0)) begin n_err++; $display("FAIL scan_tick cyc %0d got %b want %b", k, tick, (k % 4) == 0); end
            n_vec++; if (frame_done !== ((k % 16) == 0)) begin n_err++; $display("FAIL scan_frame_done cyc %0d got %b want %b", k, frame_done, (k % 16) == 0); end
            n_vec++; if (data !== 16'h0000) begin n_err++; $display("FAIL scan_data cyc %0d got %h want 0000", k, data); end
        end
    endtask

    task automatic test_load_commit();
        goto_pos(5);
        n_vec++; if (digit_sel !== 2'd1) begin n_err++; $display("FAIL lc_start_digit got %0d want 1", digit_sel); end
        load = 1'b1; data_in = 16'h1234; hex_dec_in = 1'b1; sign_in = 1'b0;
        step();
        load = 1'b0;
        n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL lc_pending got %b want 1", pending); end
        while ((pos % 16) != 15) begin
            step();
            n_vec++; if (data !== 16'h0000) begin n_err++; $display("FAIL lc_early_data pos %0d got %h want 0000", pos, data); end
        end
        step();
        n_vec++; if (data !== 16'h1234) begin n_err++; $display("FAIL lc_data got %h want 1234", data); end
        n_vec++; if (hex_dec !== 1'b1) begin n_err++; $display("FAIL lc_hex_dec got %b want 1", hex_dec); end
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL lc_pending_clr got %b want 0", pending); end
        n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL lc_frame_done got %b want 1", frame_done); end
        n_vec++; if (digit_sel !== 2'd0) begin n_err++; $display("FAIL lc_digit_sel got %0d want 0", digit_sel); end
    endtask

    task automatic test_overwrite();
        goto_pos(2);
        load = 1'b1; data_in = 16'h00AA; hex_dec_in = 1'b1; sign_in = 1'b0;
        step();
        data_in = 16'h0055; hex_dec_in = 1'b0;
        step();
        load = 1'b0;
        while ((pos % 16) != 0) begin
            step();
            if ((pos % 16) != 0) begin
                n_vec++; if (data !== 16'h1234) begin n_err++; $display("FAIL ow_hold pos %0d got %h want 1234", pos, data); end
            end
        end
        n_vec++; if (data !== 16'h0055) begin n_err++; $display("FAIL ow_data got %h want 0055", data); end
        n_vec++; if (hex_dec !== 1'b0) begin n_err++; $display("FAIL ow_hex_dec got %b want 0", hex_dec); end
        n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL ow_pending got %b want 0", pending); end
    endtask

    task automatic test_load_at_boundary();
        goto_pos(15);
        load = 1'b1; data_in = 16'h0BEE; hex_dec_in = 1'b1; sign_in = 1'b1;
        step();
        load = 1'b0;
        n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL lb_frame_done got %b want 1", frame_done); end
        n_vec++; if (data !== 16'h0055) begin n_err++; $display("FAIL lb_no_commit got %h want 0055", data); end
        n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL lb_pending got %b want 1", pending); end
        for (int i = 0; i < 15; i++) step();
        n_vec++; if (data !== 16'h0055) begin n_err++; $display("FAIL lb_before got %h want 0055", data); end
        step();
        n_vec++; if (data !== 16'h0BEE) begin n_err++; $display("FAIL lb_data got %h want 0bee", data); end
        n_vec++; if (sign !== 1'b1) begin n_err++; $display("FAIL lb_sign got %b want 1", sign); end
        n_vec++; if (hex_dec !== 1'b1) begin n_err++; $display("FAIL lb_hex_dec got %b want 1", hex_dec); end
        n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL lb_frame_done2 got %b want 1", frame_done); end
    endtask

    task automatic test_enable_freeze();
        goto_pos(5);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            load = (i == 3);
            data_in = 16'h7777; hex_dec_in = 1'b0; sign_in = 1'b0;
            step();
            n_vec++; if (digit_sel !== 2'd1) begin n_err++; $display("FAIL fz_digit_sel i %0d got %0d want 1", i, digit_sel); end
            n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL fz_tick i %0d got %b want 0", i, tick); end
        end
        load = 1'b0;
        n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL fz_pending got %b want 1", pending); end
        n_vec++; if (data !== 16'h0BEE) begin n_err++; $display("FAIL fz_data got %h want 0bee", data); end
        en = 1'b1;
        // prescaler held at 1, so three enabled edges reach the next step
        step(); step();
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL fz_resume_early got %b want 0", tick); end
        step();
        n_vec++; if (tick !== 1'b1 || digit_sel !== 2'd2) begin n_err++; $display("FAIL fz_resume_tick got %b/%0d want 1/2", tick, digit_sel); end
        goto_pos(15);
        n_vec++; if (data !== 16'h0BEE) begin n_err++; $display("FAIL fz_hold got %h want 0bee", data); end
        step();
        n_vec++; if (data !== 16'h7777) begin n_err++; $display("FAIL fz_commit got %h want 7777", data); end
        // dropping en on the wrap cycle suppresses the step
        goto_pos(7);
        en = 1'b0;
        step();
        n_vec++; if (digit_sel !== 2'd1 || tick !== 1'b0) begin n_err++; $display("FAIL fz_wrap_cycle got %0d/%b want 1/0", digit_sel, tick); end
        en = 1'b1;
        step();
        n_vec++; if (digit_sel !== 2'd2 || tick !== 1'b1) begin n_err++; $display("FAIL fz_wrap_resume got %0d/%b want 2/1", digit_sel, tick); end
    endtask

    task automatic test_async_reset();
        goto_pos(9);
        load = 1'b1; data_in = 16'hCAFE; hex_dec_in = 1'b1; sign_in = 1'b1;
        step();
        load = 1'b0;
        n_vec++; if (pending !== 1'b1 || digit_sel !== 2'd2) begin n_err++; $display("FAIL ar_pre got %b/%0d want 1/2", pending, digit_sel); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (data !== 16'h0000 || hex_dec !== 1'b0 || sign !== 1'b0) begin n_err++; $display("FAIL ar_value got %h/%b/%b want 0000/0/0", data, hex_dec, sign); end
        n_vec++; if (digit_sel !== 2'd0 || pending !== 1'b0) begin n_err++; $display("FAIL ar_state got %0d/%b want 0/0", digit_sel, pending); end
        n_vec++; if (tick !== 1'b0 || frame_done !== 1'b0) begin n_err++; $display("FAIL ar_pulses got %b/%b want 0/0", tick, frame_done); end
        step();
        rst = 1'b0; pos = 0;
        for (int i = 0; i < 4; i++) step();
        n_vec++; if (digit_sel !== 2'd1 || tick !== 1'b1) begin n_err++; $display("FAIL ar_restart got %0d/%b want 1/1", digit_sel, tick); end
        for (int i = 0; i < 12; i++) step();
        n_vec++; if (frame_done !== 1'b1 || data !== 16'h0000 || pending !== 1'b0) begin n_err++; $display("FAIL ar_discard got %b/%h/%b want 1/0000/0", frame_done, data, pending); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_scan();
        test_load_commit();
        test_overwrite();
        test_load_at_boundary();
        test_enable_freeze();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
